// File: rtl/ctrlport_reg_responder.sv
// -----------------------------------------------------------------------------
// ctrlport_reg_responder
//
// Terminal CTRL Port responder. Executes CTRL Port reads and writes against a
// local bank of NUM_REGS 32-bit registers. Every accepted request gets exactly
// one response. Timed requests can be held until the local time reaches the
// request timestamp.
//
// Handshake: CTRL Port has no ready signal. A request is a one-cycle strobe on
// s_ctrlport_req_wr / s_ctrlport_req_rd, and the remaining req_* fields are
// valid in that same cycle. A strobe is accepted only while the responder is
// idle. A strobe that arrives while a request is pending or being answered is
// dropped, and the sticky req_dropped flag is set. The response is the
// one-cycle strobe s_ctrlport_resp_ack. status/data are qualified by ack and
// read as zero at every other time.
//
// Optional feature macro: CTRLPORT_REG_RESPONDER_TIMED_EN
//   defined     : timed requests wait in WAIT_TIME until time_now >= req_time.
//                 A timestamp that is already in the past returns TSERR.
//   not defined : WAIT_TIME does not exist and time_now is ignored. Any request
//                 with has_time=1 returns CMDERR without executing.
//
// Parameters:
//   NUM_REGS  : number of 32-bit registers (1..64)
//   BASE_ADDR : byte address of register 0 (4-byte aligned)
//   RESET_VAL : reset value of every register
//
// Ports:
//   ctrlport_clk, ctrlport_rst    : clock, asynchronous active-high reset
//   s_ctrlport_req_*              : CTRL Port request (wr/rd strobes, addr,
//                                   data, byte_en, has_time, time)
//   s_ctrlport_resp_ack/status/data : registered response
//   time_now                      : local time, ctrlport_clk domain
//   regs                          : flattened register contents, reg i at [32*i+:32]
//   reg_wr_stb                    : one-cycle pulse per register on update
//   req_dropped                   : sticky, a request arrived while busy
//   o_dbg_state                   : current FSM state encoding (debug)
// -----------------------------------------------------------------------------
`default_nettype none

module ctrlport_reg_responder #(
    parameter int          NUM_REGS  = 8,
    parameter int          BASE_ADDR = 0,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                   ctrlport_clk,
    input  logic                   ctrlport_rst,
    input  logic                   s_ctrlport_req_wr,
    input  logic                   s_ctrlport_req_rd,
    input  logic [19:0]            s_ctrlport_req_addr,
    input  logic [31:0]            s_ctrlport_req_data,
    input  logic [3:0]             s_ctrlport_req_byte_en,
    input  logic                   s_ctrlport_req_has_time,
    input  logic [63:0]            s_ctrlport_req_time,
    output logic                   s_ctrlport_resp_ack,
    output logic [1:0]             s_ctrlport_resp_status,
    output logic [31:0]            s_ctrlport_resp_data,
    input  logic [63:0]            time_now,
    output logic [32*NUM_REGS-1:0] regs,
    output logic [NUM_REGS-1:0]    reg_wr_stb,
    output logic                   req_dropped,
    output logic [1:0]             o_dbg_state
);

    localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);
    localparam logic [31:0] LP_SPAN = 32'(4 * NUM_REGS);

    localparam logic [1:0] ST_OKAY   = 2'd0;
    localparam logic [1:0] ST_CMDERR = 2'd1;
    localparam logic [1:0] ST_TSERR  = 2'd2;

`ifdef CTRLPORT_REG_RESPONDER_TIMED_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TIME = 2'd1,
        S_RESP      = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd2
    } state_t;
`endif

    state_t r_state;
    state_t w_state_nxt;

    // Register bank and registered outputs
    logic [31:0]         r_regs [NUM_REGS];
    logic                r_resp_ack;
    logic [1:0]          r_resp_status;
    logic [31:0]         r_resp_data;
    logic [NUM_REGS-1:0] r_reg_wr_stb;
    logic                r_req_dropped;

    // Request decode
    logic              w_req;
    logic              w_both;
    logic [31:0]       w_addr_ext;
    logic [32:0]       w_diff;
    logic              w_addr_ok;
    logic [IDX_W-1:0]  w_req_idx;

    // FSM decisions
    logic              w_resp;
    logic [1:0]        w_resp_status;
    logic              w_exec;
    logic              w_capture;
    logic              w_drop;

    // Operands of the command being executed this cycle
    logic              w_ex_wr;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [31:0]       w_ex_data;
    logic [3:0]        w_ex_be;

    assign w_req  = s_ctrlport_req_wr | s_ctrlport_req_rd;
    assign w_both = s_ctrlport_req_wr & s_ctrlport_req_rd;

    // Range check through a 33-bit subtraction: bit 32 set means the address
    // is below BASE_ADDR. This avoids a compare that degenerates to a constant
    // when BASE_ADDR is 0.
    assign w_addr_ext = {12'd0, s_ctrlport_req_addr};
    assign w_diff     = {1'b0, w_addr_ext} - {1'b0, LP_BASE};
    assign w_addr_ok  = (s_ctrlport_req_addr[1:0] == 2'b00) &&
                        !w_diff[32] &&
                        (w_diff[31:0] < LP_SPAN);
    assign w_req_idx  = IDX_W'(w_diff[31:0] >> 2);

`ifdef CTRLPORT_REG_RESPONDER_TIMED_EN
    // Timed request held while waiting for its timestamp. Only successfully
    // decoded requests are captured, so no error state is stored here.
    logic              r_cap_wr;
    logic [IDX_W-1:0]  r_cap_idx;
    logic [31:0]       r_cap_data;
    logic [3:0]        r_cap_be;
    logic [63:0]       r_cap_time;

    // Untimed commands execute straight from the request bus. Timed ones
    // execute from the captured copy.
    assign w_ex_wr   = (r_state == S_WAIT_TIME) ? r_cap_wr   : s_ctrlport_req_wr;
    assign w_ex_idx  = (r_state == S_WAIT_TIME) ? r_cap_idx  : w_req_idx;
    assign w_ex_data = (r_state == S_WAIT_TIME) ? r_cap_data : s_ctrlport_req_data;
    assign w_ex_be   = (r_state == S_WAIT_TIME) ? r_cap_be   : s_ctrlport_req_byte_en;

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_cap_wr   <= 1'b0;
            r_cap_idx  <= '0;
            r_cap_data <= '0;
            r_cap_be   <= '0;
            r_cap_time <= '0;
        end else if (w_capture) begin
            r_cap_wr   <= s_ctrlport_req_wr;
            r_cap_idx  <= w_req_idx;
            r_cap_data <= s_ctrlport_req_data;
            r_cap_be   <= s_ctrlport_req_byte_en;
            r_cap_time <= s_ctrlport_req_time;
        end
    end
`else
    assign w_ex_wr   = s_ctrlport_req_wr;
    assign w_ex_idx  = w_req_idx;
    assign w_ex_data = s_ctrlport_req_data;
    assign w_ex_be   = s_ctrlport_req_byte_en;

    // Time inputs have no function in the untimed build.
    logic w_unused_time;
    assign w_unused_time = ^{time_now, s_ctrlport_req_time};
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and per-cycle decisions.
    // w_resp issues the response that becomes visible next cycle (the cycle
    // spent in S_RESP). w_exec marks that the command itself runs on the same
    // edge, so the register update and the ack appear together.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_resp        = 1'b0;
        w_resp_status = ST_OKAY;
        w_exec        = 1'b0;
        w_capture     = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_RESP;
                    w_resp      = 1'b1;
                    if (w_both || !w_addr_ok) begin
                        w_resp_status = ST_CMDERR;
                    end else if (s_ctrlport_req_has_time) begin
`ifdef CTRLPORT_REG_RESPONDER_TIMED_EN
                        if (s_ctrlport_req_time < time_now) begin
                            w_resp_status = ST_TSERR;
                        end else begin
                            // Even a timestamp equal to the current time goes
                            // through WAIT_TIME. The check there succeeds on
                            // the next cycle.
                            w_resp      = 1'b0;
                            w_capture   = 1'b1;
                            w_state_nxt = S_WAIT_TIME;
                        end
`else
                        w_resp_status = ST_CMDERR;
`endif
                    end else begin
                        w_exec = 1'b1;
                    end
                end
            end
`ifdef CTRLPORT_REG_RESPONDER_TIMED_EN
            S_WAIT_TIME: begin
                w_drop = w_req;
                if (time_now >= r_cap_time) begin
                    w_state_nxt = S_RESP;
                    w_resp      = 1'b1;
                    w_exec      = 1'b1;
                end
            end
`endif
            S_RESP: begin
                // The ack cycle still counts as busy.
                w_drop      = w_req;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register bank, response and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_resp_ack    <= 1'b0;
            r_resp_status <= ST_OKAY;
            r_resp_data   <= '0;
            r_reg_wr_stb  <= '0;
            r_req_dropped <= 1'b0;
        end else begin
            r_resp_ack    <= w_resp;
            r_resp_status <= w_resp_status;
            r_reg_wr_stb  <= '0;
            r_resp_data   <= '0;

            if (w_exec) begin
                if (w_ex_wr) begin
                    // The strobe fires even with all byte enables low.
                    r_reg_wr_stb[w_ex_idx] <= 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        if (w_ex_be[k]) begin
                            r_regs[w_ex_idx][8*k +: 8] <= w_ex_data[8*k +: 8];
                        end
                    end
                end else begin
                    r_resp_data <= r_regs[w_ex_idx];
                end
            end

            if (w_drop) begin
                r_req_dropped <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs[32*g +: 32] = r_regs[g];
        end
    endgenerate

    assign s_ctrlport_resp_ack    = r_resp_ack;
    assign s_ctrlport_resp_status = r_resp_status;
    assign s_ctrlport_resp_data   = r_resp_data;
    assign reg_wr_stb             = r_reg_wr_stb;
    assign req_dropped            = r_req_dropped;
    assign o_dbg_state            = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ctrlport_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_ctrlport_reg_responder
//
// Directed and randomized requests for ctrlport_reg_responder. Expected
// responses, latencies and register contents come from a reference model of
// the register bank, which is written as a plain array.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ctrlport_reg_responder;

    localparam int          NUM_REGS  = 8;
    localparam int          BASE_ADDR = 'h100;
    localparam logic [31:0] RESET_VAL = 32'hDEADBEEF;

`ifdef CTRLPORT_REG_RESPONDER_TIMED_EN
    localparam bit TIMED = 1'b1;
`else
    localparam bit TIMED = 1'b0;
`endif

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] CMDERR = 2'd1;
    localparam logic [1:0] TSERR  = 2'd2;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   req_wr;
    logic                   req_rd;
    logic [19:0]            req_addr;
    logic [31:0]            req_data;
    logic [3:0]             req_be;
    logic                   req_has_time;
    logic [63:0]            req_time;
    logic                   resp_ack;
    logic [1:0]             resp_status;
    logic [31:0]            resp_data;
    logic [63:0]            time_now;
    logic [32*NUM_REGS-1:0] regs;
    logic [NUM_REGS-1:0]    reg_wr_stb;
    logic                   req_dropped;
    logic [1:0]             dbg_state;

    ctrlport_reg_responder #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .ctrlport_clk            (clk),
        .ctrlport_rst            (rst),
        .s_ctrlport_req_wr       (req_wr),
        .s_ctrlport_req_rd       (req_rd),
        .s_ctrlport_req_addr     (req_addr),
        .s_ctrlport_req_data     (req_data),
        .s_ctrlport_req_byte_en  (req_be),
        .s_ctrlport_req_has_time (req_has_time),
        .s_ctrlport_req_time     (req_time),
        .s_ctrlport_resp_ack     (resp_ack),
        .s_ctrlport_resp_status  (resp_status),
        .s_ctrlport_resp_data    (resp_data),
        .time_now                (time_now),
        .regs                    (regs),
        .reg_wr_stb              (reg_wr_stb),
        .req_dropped             (req_dropped),
        .o_dbg_state             (dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int           n_chk = 0;
    int           n_err = 0;
    logic [31:0]  exp_regs [NUM_REGS];
    logic         exp_dropped;
    logic [33:0]  exp_q [$];   // {status, data} of each expected response

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [32*NUM_REGS-1:0] e;
        for (int i = 0; i < NUM_REGS; i++) e[32*i +: 32] = exp_regs[i];
        n_chk++;
        assert (regs === e) else begin
            n_err++;
            $error("FAIL %s/regs: observed 0x%0h expected 0x%0h", tag, regs, e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/ack"},     {63'd0, resp_ack}, 64'd0);
        check({tag, "/status"},  {62'd0, resp_status}, 64'd0);
        check({tag, "/data"},    {32'd0, resp_data}, 64'd0);
        check({tag, "/wr_stb"},  {56'd0, reg_wr_stb}, 64'd0);
        check({tag, "/dropped"}, {63'd0, req_dropped}, {63'd0, exp_dropped});
        check_regs(tag);
    endtask

    // ---------------------------------------------------------------- driver tasks
    // Each cycle boundary: active edge, then #1 to sample outputs and drive inputs.
    // time_now advances by one per cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        time_now = time_now + 64'd1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RESET_VAL;
        exp_dropped = 1'b0;
        exp_q.delete();
    endtask

    // Issue one request and check its response. poke=1 raises an extra read
    // strobe in the cycle after the request, while the responder is busy.
    task automatic do_req(input string tag, input logic wr, input logic rd,
                          input logic [19:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic ht,
                          input logic [63:0] t, input bit poke);
        int a, idx, lat, exp_lat;
        bit ok, exec;
        logic [1:0]          e_stat;
        logic [31:0]         e_data;
        logic [NUM_REGS-1:0] e_stb;
        logic [33:0]         e_resp;

        // Reference model: decode and rules applied directly.
        a   = int'(addr);
        ok  = (a % 4 == 0) && (a >= BASE_ADDR) && (a < BASE_ADDR + 4 * NUM_REGS);
        idx = ok ? (a - BASE_ADDR) / 4 : 0;
        exec    = 1'b0;
        e_stat  = OKAY;
        e_data  = 32'd0;
        e_stb   = '0;
        exp_lat = 1;
        if ((wr && rd) || !ok || (ht && !TIMED)) begin
            e_stat = CMDERR;
        end else if (ht && (t < time_now)) begin
            e_stat = TSERR;
        end else begin
            exec = 1'b1;
            // Timed: first eligible cycle is at least one after acceptance,
            // and the ack follows one cycle after that.
            if (ht) exp_lat = 1 + (((t - time_now) > 64'd1) ? int'(t - time_now) : 1);
        end
        if (exec && wr) begin
            for (int k = 0; k < 4; k++) if (be[k]) exp_regs[idx][8*k +: 8] = data[8*k +: 8];
            e_stb[idx] = 1'b1;
        end else if (exec) begin
            e_data = exp_regs[idx];
        end
        exp_q.push_back({e_stat, e_data});

        req_wr = wr; req_rd = rd; req_addr = addr; req_data = data;
        req_be = be; req_has_time = ht; req_time = t;
        tick();
        req_wr = 1'b0;
        req_rd = poke;
        if (poke) exp_dropped = 1'b1;
        lat = 1;
        while (resp_ack !== 1'b1 && lat < 64) begin
            tick();
            req_rd = 1'b0;
            lat++;
        end
        e_resp = exp_q.pop_front();
        check({tag, "/ack"},     {63'd0, resp_ack}, 64'd1);
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/status"},  {62'd0, resp_status}, {62'd0, e_resp[33:32]});
        check({tag, "/data"},    {32'd0, resp_data}, {32'd0, e_resp[31:0]});
        check({tag, "/wr_stb"},  {56'd0, reg_wr_stb}, {56'd0, e_stb});
        check_regs(tag);
        tick();
        req_rd = 1'b0;
        check({tag, "/one_pulse"}, {21'd0, resp_ack, resp_status, resp_data, reg_wr_stb}, 64'd0);
        check({tag, "/dropped"}, {63'd0, req_dropped}, {63'd0, exp_dropped});
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [19:0] addr;
        logic        wr, rd, ht;
        logic [63:0] t;
        int          sel, kind, n_ack;

        req_wr = 1'b0; req_rd = 1'b0; req_addr = '0; req_data = '0;
        req_be = '0; req_has_time = 1'b0; req_time = '0;
        time_now = 64'd0;
        model_reset();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset");

        // Read register 1: reset value.
        do_req("rd_reg1", 1'b0, 1'b1, 20'(BASE_ADDR + 4), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        // Partial write to register 2, then readback.
        do_req("wr_reg2", 1'b1, 1'b0, 20'(BASE_ADDR + 8), 32'h11223344, 4'b0101, 1'b0, 64'd0, 1'b0);
        do_req("rd_reg2", 1'b0, 1'b1, 20'(BASE_ADDR + 8), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        // Write with no byte enables still pulses the strobe.
        do_req("wr_be0", 1'b1, 1'b0, 20'(BASE_ADDR + 28), 32'hFFFFFFFF, 4'b0000, 1'b0, 64'd0, 1'b0);
        // Decode errors.
        do_req("rd_past_end", 1'b0, 1'b1, 20'(BASE_ADDR + 4 * NUM_REGS), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        do_req("rd_unaligned", 1'b0, 1'b1, 20'(BASE_ADDR + 2), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        do_req("wr_unaligned", 1'b1, 1'b0, 20'(BASE_ADDR + 9), 32'h12345678, 4'hF, 1'b0, 64'd0, 1'b0);
        do_req("rd_below", 1'b0, 1'b1, 20'(BASE_ADDR - 4), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        do_req("wr_and_rd", 1'b1, 1'b1, 20'(BASE_ADDR), 32'hCAFEF00D, 4'hF, 1'b0, 64'd0, 1'b0);

        // Timed requests.
        time_now = 64'd100;
        do_req("timed_wr_110", 1'b1, 1'b0, 20'(BASE_ADDR + 12), 32'hA5A5_0001, 4'hF, 1'b1, 64'd110, 1'b0);
        time_now = 64'd100;
        do_req("timed_wr_50", 1'b1, 1'b0, 20'(BASE_ADDR + 16), 32'hA5A5_0002, 4'hF, 1'b1, 64'd50, 1'b0);
        do_req("timed_rd_now", 1'b0, 1'b1, 20'(BASE_ADDR + 12), 32'd0, 4'h0, 1'b1, time_now, 1'b0);
        do_req("rd_reg3", 1'b0, 1'b1, 20'(BASE_ADDR + 12), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);
        do_req("rd_reg4", 1'b0, 1'b1, 20'(BASE_ADDR + 16), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);

        // Randomized traffic.
        time_now = 64'd1000;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: addr = 20'(BASE_ADDR + 4 * int'($urandom_range(0, NUM_REGS - 1)) + int'($urandom_range(1, 3)));
                1: addr = 20'(BASE_ADDR + 4 * NUM_REGS + 4 * int'($urandom_range(0, 3)));
                2: addr = 20'(BASE_ADDR - 4 * int'($urandom_range(1, 4)));
                default: addr = 20'(BASE_ADDR + 4 * int'($urandom_range(0, NUM_REGS - 1)));
            endcase
            kind = int'($urandom_range(0, 9));
            wr = (kind < 5) || (kind == 9);
            rd = (kind >= 5);
            ht = ($urandom_range(0, 3) == 0);
            t  = time_now + 64'($urandom_range(0, 12)) - 64'd4;
            do_req("rand", wr, rd, addr, $urandom, 4'($urandom_range(0, 15)), ht, t, 1'b0);
        end

        // Strobe while busy is ignored; the original request is still answered once.
        time_now = 64'd200;
        do_req("busy_drop", 1'b1, 1'b0, 20'(BASE_ADDR + 24), 32'h0BAD_F00D, 4'hF, 1'b1, 64'd205, 1'b1);
        do_req("after_drop", 1'b0, 1'b1, 20'(BASE_ADDR + 24), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);

        // Reset while a timed request waits: it must never be acknowledged.
        time_now = 64'd500;
        req_wr = 1'b1; req_rd = 1'b0; req_addr = 20'(BASE_ADDR + 20);
        req_data = 32'h5555AAAA; req_be = 4'hF; req_has_time = 1'b1; req_time = 64'd520;
        tick();
        req_wr = 1'b0;
        req_has_time = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        check_idle_outputs("in_reset");
        tick();
        tick();
        rst = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (resp_ack === 1'b1) n_ack++;
        end
        check("post_reset/no_ack", 64'(n_ack), 64'd0);
        check_idle_outputs("post_reset");

        // Still functional after reset.
        do_req("post_reset_rd", 1'b0, 1'b1, 20'(BASE_ADDR + 20), 32'd0, 4'h0, 1'b0, 64'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrlport_reg_responder.md
# ctrlport_reg_responder

Terminal CTRL Port responder: accepts CTRL Port requests from an initiator or a clock crossing, executes reads and writes against a local bank of 32-bit registers, and returns exactly one response per accepted request. Optionally holds timed requests until the local time reaches the request timestamp. It sits at the master side of a CTRL Port clock crossing, inside an RFNoC block's register space.

## Interface

Parameters:
- NUM_REGS, 8: number of 32-bit registers (1..64)
- BASE_ADDR, 0: byte address of register 0; 4-byte aligned
- RESET_VAL, 0: reset value of every register (32 bits)

Ports:
- ctrlport_clk  in  1  sole clock
- ctrlport_rst  in  1  asynchronous, active-high reset
- s_ctrlport_req_wr  in  1  write request strobe (one-cycle pulse)
- s_ctrlport_req_rd  in  1  read request strobe (one-cycle pulse)
- s_ctrlport_req_addr  in  20  byte address
- s_ctrlport_req_data  in  32  write data
- s_ctrlport_req_byte_en  in  4  write byte enables
- s_ctrlport_req_has_time  in  1  request is timed
- s_ctrlport_req_time  in  64  execution timestamp
- s_ctrlport_resp_ack  out  1  response strobe (one-cycle pulse)
- s_ctrlport_resp_status  out  2  0 OKAY, 1 CMDERR, 2 TSERR
- s_ctrlport_resp_data  out  32  read data; 0 for writes and errors
- time_now  in  64  current local time, increments in ctrlport_clk domain
- regs  out  32*NUM_REGS  flattened register contents, register i at [32*i+:32]
- reg_wr_stb  out  NUM_REGS  one-cycle pulse on the cycle a register is updated
- req_dropped  out  1  sticky: a request arrived while busy

## Operation

- States: IDLE, WAIT_TIME, RESP. Request accepted only in IDLE.
- Decode: valid iff addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; index = (addr-BASE_ADDR)>>2.
- wr and rd together in one cycle: CMDERR, no register change.
- Invalid address: CMDERR, no register change, data 0.
- Write: per byte lane k with byte_en[k]=1, regs[index][8k+:8] <= data[8k+:8]; reg_wr_stb[index] pulses even when byte_en=0.
- Read: resp_data = regs[index] as sampled on the response cycle.
- Untimed (or decode error): IDLE -> RESP; register update and ack happen together in RESP, then -> IDLE.
- Timed, time valid: if req_time < time_now at acceptance -> RESP with TSERR, no execution. Else -> WAIT_TIME; hold captured request; when time_now >= req_time, -> RESP, execute, OKAY.
- Request strobe while in WAIT_TIME or RESP: ignored, req_dropped <= 1 (cleared only by reset).
- Comparisons are unsigned 64-bit; no wrap handling.

## Timing

- Reset values: resp_ack 0, resp_status 0, resp_data 0, regs all RESET_VAL, reg_wr_stb 0, req_dropped 0, state IDLE.
- Untimed latency: request in cycle N, ack and register update in cycle N+1.
- Timed: ack in cycle M+1 where M is the first cycle with time_now >= req_time (M >= N+1).
- Earliest next accepted request: cycle after ack (ack cycle itself counts as busy).
- All outputs registered; status/data valid only while ack=1, otherwise 0.
- Reset during WAIT_TIME: pending request discarded, no ack ever issued.

## Configuration

- CTRLPORT_REG_RESPONDER_TIMED_EN defined: timed behaviour as above; WAIT_TIME state present.
- Not defined: WAIT_TIME removed, time_now unused; any request with has_time=1 returns CMDERR in cycle N+1 without execution.

## Test plan

- Reset, read addr BASE_ADDR+4 with RESET_VAL=0xDEADBEEF -> ack at N+1, OKAY, data 0xDEADBEEF.
- Write 0x11223344 byte_en 4'b0101 to register 2 (prior 0) -> reg_wr_stb[2] pulse at N+1, regs[2]=0x00220044; readback matches.
- Read addr BASE_ADDR+4*NUM_REGS, addr BASE_ADDR+2, and wr+rd together -> each CMDERR, data 0, no register change.
- TIMED_EN: time_now=100, timed write at 110 -> ack when time_now>=110 sampled, OKAY; timed write at 50 -> TSERR next cycle, register unchanged.
- Second request while in WAIT_TIME -> ignored, req_dropped=1, first request still acked once; then reset mid-WAIT_TIME -> no ack, all outputs at reset values.
- Without TIMED_EN: timed read at any time -> CMDERR at N+1, data 0.
